axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 162 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter merging N_CH SRAM-like read channels onto one single-beat AXI read port.
// Each channel uses its own index as AXI ID, so per-channel return order follows AXI same-ID ordering.
module axi_rd_arbiter #(
    parameter int N_CH    = 2,
    parameter int MAX_OUT = 2,
    parameter int ID_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      m_req,
    input  logic [2*N_CH-1:0]    m_size,
    input  logic [32*N_CH-1:0]   m_addr,
    output logic [N_CH-1:0]      m_addr_ok,
    output logic [N_CH-1:0]      m_data_ok,
    output logic [31:0]          m_rdata,
    output logic [ID_W-1:0]      arid,
    output logic [31:0]          araddr,
    output logic [2:0]           arsize,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [ID_W-1:0]      rid,
    input  logic [31:0]          rdata,
    input  logic                 rvalid,
    output logic                 rready,
    output logic                 err
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUT);
    localparam logic [CH_W-1:0]  LAST_INIT = CH_W'(N_CH - 1);

    logic [CNT_W-1:0] r_cnt [N_CH];
    logic [CH_W-1:0]  r_lastGrant;
    logic             r_arvalid;
    logic [ID_W-1:0]  r_arid;
    logic [31:0]      r_araddr;
    logic [1:0]       r_arsize;
    logic [N_CH-1:0]  r_dataOk;
    logic [31:0]      r_rdata;
    logic             r_err;

    logic             w_slotFree;
    logic             w_found;
    logic             w_rAccept;
    logic             w_rKnown;
    logic             w_rBad;
    logic [N_CH-1:0]  w_elig;
    logic [N_CH-1:0]  w_addrOk;
    logic [N_CH-1:0]  w_rMatch;
    logic [CH_W-1:0]  w_grantIdx;
    logic [31:0]      w_grantAddr;
    logic [1:0]       w_grantSize;

    assign rready     = !reset;
    assign w_slotFree = !r_arvalid || arready;
    assign w_rAccept  = rvalid && rready;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_elig[i] = m_req[i] && (r_cnt[i] < CNT_MAX);
        end
    end

    // Search starts one past the last winner so every eligible channel is served within N_CH grants.
    always_comb begin
        w_found    = 1'b0;
        w_grantIdx = '0;
        for (int off = 1; off <= N_CH; off++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!w_found && w_elig[i] && (i == (int'(r_lastGrant) + off) % N_CH)) begin
                    w_found    = 1'b1;
                    w_grantIdx = CH_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_addrOk    = '0;
        w_grantAddr = '0;
        w_grantSize = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (CH_W'(i) == w_grantIdx) begin
                w_grantAddr = m_addr[32*i +: 32];
                w_grantSize = m_size[2*i +: 2];
            end
            w_addrOk[i] = !reset && w_slotFree && w_found && (CH_W'(i) == w_grantIdx);
        end
    end

    // A response is only legal for a channel that actually has a read outstanding.
    always_comb begin
        w_rMatch = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_rMatch[i] = w_rAccept && (rid == ID_W'(i)) && (r_cnt[i] != '0);
        end
        w_rKnown = |w_rMatch;
        w_rBad   = w_rAccept && !w_rKnown;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_arvalid   <= 1'b0;
            r_arid      <= '0;
            r_araddr    <= '0;
            r_arsize    <= '0;
            r_lastGrant <= LAST_INIT;
        end else if (w_slotFree) begin
            r_arvalid <= w_found;
            if (w_found) begin
                r_arid      <= ID_W'(w_grantIdx);
                r_araddr    <= w_grantAddr;
                r_arsize    <= w_grantSize;
                r_lastGrant <= w_grantIdx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_addrOk[i] && !w_rMatch[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (!w_addrOk[i] && w_rMatch[i]) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dataOk <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_dataOk <= w_rMatch;
            if (w_rKnown) begin
                r_rdata <= rdata;
            end
            if (w_rBad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign m_addr_ok = w_addrOk;
    assign m_data_ok = r_dataOk;
    assign m_rdata   = r_rdata;
    assign arvalid   = r_arvalid;
    assign arid      = r_arid;
    assign araddr    = r_araddr;
    assign arsize    = {1'b0, r_arsize};
    assign err       = r_err;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter (2 channels, 2 outstanding) against a cycle-level
// reference model of the arbitration, counting and response-routing rules.
module tb_axi_rd_arbiter;

    localparam int N_CH    = 2;
    localparam int MAX_OUT = 2;
    localparam int ID_W    = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [N_CH-1:0]     m_req;
    logic [2*N_CH-1:0]   m_size;
    logic [32*N_CH-1:0]  m_addr;
    logic [N_CH-1:0]     m_addr_ok;
    logic [N_CH-1:0]     m_data_ok;
    logic [31:0]         m_rdata;
    logic [ID_W-1:0]     arid;
    logic [31:0]         araddr;
    logic [2:0]          arsize;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [31:0]         rdata;
    logic                rvalid;
    logic                rready;
    logic                err;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state
    int           mCnt [N_CH];
    int           mLast;
    bit           mArValid;
    logic [31:0]  mArAddr;
    int           mArId;
    int           mArSize;
    logic [1:0]   mDataOk;
    logic [31:0]  mRdata;
    bit           mErr;

    // Values observed during the most recent applyStimulus cycle
    logic [1:0]   lastAddrOk;
    logic [1:0]   lastDataOk;
    logic [31:0]  lastRdata;
    logic [31:0]  lastAraddr;
    logic [3:0]   lastArid;
    logic [2:0]   lastArsize;
    logic         lastArvalid;
    logic         lastErr;

    axi_rd_arbiter #(.N_CH(N_CH), .MAX_OUT(MAX_OUT), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_size(m_size), .m_addr(m_addr),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N_CH; i++) mCnt[i] = 0;
        mLast    = N_CH - 1;
        mArValid = 0;
        mArAddr  = '0;
        mArId    = 0;
        mArSize  = 0;
        mDataOk  = '0;
        mRdata   = '0;
        mErr     = 0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset   = 1'b1;
        m_req   = '0;
        m_size  = '0;
        m_addr  = '0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rid     = '0;
        rdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rreadyInReset", 32'(rready), 32'd0);
        checkOutput("addrOkInReset", 32'(m_addr_ok), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    // One clock cycle: drive inputs, check every output against the model, then advance the model.
    task automatic applyStimulus(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [1:0] s0, input logic [1:0] s1, input logic ard,
                                 input logic rv, input logic [3:0] ridIn, input logic [31:0] rd);
        int   grant;
        int   c;
        bit   slotFree;
        bit   good;
        logic [1:0] expAddrOk;
        @(negedge clk);
        m_req   = req;
        m_addr  = {a1, a0};
        m_size  = {s1, s0};
        arready = ard;
        rvalid  = rv;
        rid     = ridIn;
        rdata   = rd;
        #1;
        slotFree = !mArValid || ard;
        grant = -1;
        if (slotFree) begin
            for (int off = 1; off <= N_CH; off++) begin
                c = (mLast + off) % N_CH;
                if (grant < 0 && req[c] && mCnt[c] < MAX_OUT) grant = c;
            end
        end
        expAddrOk = (grant >= 0) ? 2'(1 << grant) : 2'b00;

        lastAddrOk  = m_addr_ok;
        lastDataOk  = m_data_ok;
        lastRdata   = m_rdata;
        lastAraddr  = araddr;
        lastArid    = arid;
        lastArsize  = arsize;
        lastArvalid = arvalid;
        lastErr     = err;

        checkOutput("addrOk", 32'(m_addr_ok), 32'(expAddrOk));
        checkOutput("arvalid", 32'(arvalid), 32'(mArValid));
        checkOutput("araddr", araddr, mArAddr);
        checkOutput("arid", 32'(arid), 32'(mArId));
        checkOutput("arsize", 32'(arsize), 32'(mArSize));
        checkOutput("dataOk", 32'(m_data_ok), 32'(mDataOk));
        checkOutput("rdata", m_rdata, mRdata);
        checkOutput("err", 32'(err), 32'(mErr));
        checkOutput("rready", 32'(rready), 32'd1);

        @(posedge clk);
        good = 0;
        if (rv && ridIn < N_CH) good = (mCnt[ridIn] > 0);
        if (grant >= 0) mCnt[grant]++;
        if (good) mCnt[ridIn]--;
        mDataOk = good ? 2'(1 << ridIn) : 2'b00;
        if (good) mRdata = rd;
        if (rv && !good) mErr = 1;
        if (slotFree) begin
            mArValid = (grant >= 0);
            if (grant >= 0) begin
                mArAddr = (grant == 0) ? a0 : a1;
                mArSize = (grant == 0) ? int'(s0) : int'(s1);
                mArId   = grant;
                mLast   = grant;
            end
        end
    endtask

    task automatic idle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b0, 4'd0, 32'h0);
    endtask

    initial begin
        logic [1:0]  rq;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  s0;
        logic [1:0]  s1;
        logic        ard;
        logic        rv;
        logic [3:0]  r;
        logic [1:0]  expSeq [6];

        modelReset();
        resetDut();

        // Reset state and single read on channel 0
        idle();
        applyStimulus(2'b01, 32'h1c000000, 32'h0, 2'd2, 2'd0, 1'b1, 1'b0, 4'd0, 32'h0);
        checkOutput("s036AddrOk", 32'(lastAddrOk), 32'h1);
        idle();
        checkOutput("s036Arvalid", 32'(lastArvalid), 32'd1);
        checkOutput("s036Araddr", lastAraddr, 32'h1c000000);
        checkOutput("s036Arid", 32'(lastArid), 32'd0);
        checkOutput("s036Arsize", 32'(lastArsize), 32'd2);
        idle();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b1, 4'd0, 32'h12345678);
        idle();
        checkOutput("s036DataOk", 32'(lastDataOk), 32'h1);
        checkOutput("s036Rdata", lastRdata, 32'h12345678);

        // Both channels requesting: grants alternate
        resetDut();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(2'b11, 32'h1000 + 32'(k), 32'h2000 + 32'(k), 2'd1, 2'd2, 1'b1,
                          (k >= 2), 4'(k % 2), 32'hA000 + 32'(k));
            checkOutput("s037Alternate", 32'(lastAddrOk), (k % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Outstanding limit on channel 0
        resetDut();
        expSeq = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
        for (int k = 0; k < 6; k++) begin
            applyStimulus(2'b01, 32'h3000 + 32'(4*k), 32'h0, 2'd2, 2'd0, 1'b1,
                          (k == 4), 4'd0, 32'hBEEF0000 + 32'(k));
            checkOutput("s038Limit", 32'(lastAddrOk), 32'(expSeq[k]));
        end

        // AR stall holds address channel stable
        resetDut();
        applyStimulus(2'b01, 32'h4444_0000, 32'h0, 2'd1, 2'd0, 1'b0, 1'b0, 4'd0, 32'h0);
        checkOutput("s039FirstGrant", 32'(lastAddrOk), 32'h1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b10, 32'h0, 32'h5555_0000, 2'd0, 2'd2, 1'b0, 1'b0, 4'd0, 32'h0);
            checkOutput("s039StallAddrOk", 32'(lastAddrOk), 32'h0);
            checkOutput("s039StallAraddr", lastAraddr, 32'h4444_0000);
            checkOutput("s039StallArid", 32'(lastArid), 32'd0);
        end
        applyStimulus(2'b10, 32'h0, 32'h5555_0000, 2'd0, 2'd2, 1'b1, 1'b0, 4'd0, 32'h0);
        checkOutput("s039ReleaseGrant", 32'(lastAddrOk), 32'h2);

        // Out-of-range ID sets a sticky error
        resetDut();
        applyStimulus(2'b00, 32'h0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b1, 4'd5, 32'hDEADBEEF);
        for (int k = 0; k < 4; k++) begin
            idle();
            checkOutput("s040Err", 32'(lastErr), 32'd1);
            checkOutput("s040NoDataOk", 32'(lastDataOk), 32'd0);
            checkOutput("s040RdataKept", lastRdata, 32'd0);
        end

        // Reset with a read in flight, then a late response
        resetDut();
        applyStimulus(2'b01, 32'h6000, 32'h0, 2'd2, 2'd0, 1'b1, 1'b0, 4'd0, 32'h0);
        idle();
        resetDut();
        idle();
        checkOutput("s034ErrClearedByReset", 32'(lastErr), 32'd0);
        applyStimulus(2'b00, 32'h0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b1, 4'd0, 32'h77777777);
        idle();
        checkOutput("s034LateErr", 32'(lastErr), 32'd1);
        checkOutput("s034LateNoData", 32'(lastDataOk), 32'd0);

        // Randomized traffic with only legal responses
        resetDut();
        for (int k = 0; k < 400; k++) begin
            rq  = 2'($urandom);
            a0  = $urandom;
            a1  = $urandom;
            s0  = 2'($urandom_range(0, 2));
            s1  = 2'($urandom_range(0, 2));
            ard = ($urandom_range(0, 3) != 0);
            rv  = 1'b0;
            r   = 4'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0 && mCnt[r] > 0) rv = 1'b1;
            applyStimulus(rq, a0, a1, s0, s1, ard, rv, r, $urandom);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
